// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter sharing one single-port memory between the fetch (IF) and
// data (DM) ports; data port wins, and a watchdog forces completion on a silent memory.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEADBEEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DM_BUSY = 2'd1;
  localparam logic [1:0] S_IF_BUSY = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state;
  logic          owner_dm;
  logic          kill;
  logic [WW-1:0] wd;
  logic          grant_dm;
  logic          grant_if;
  logic          timeout;
  logic          busy;

  assign busy    = (state == S_DM_BUSY) || (state == S_IF_BUSY);
  assign timeout = (wd == WW'(TIMEOUT - 1));

  // In DONE only the port that did not just complete may be granted; its own req is still high.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (state == S_IDLE) begin
      grant_dm = dm_req;
      grant_if = ~dm_req & if_req & ~if_flush;
    end else if (state == S_DONE) begin
      if (owner_dm) grant_if = if_req & ~if_flush;
      else          grant_dm = dm_req;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner_dm  <= 1'b0;
      kill      <= 1'b0;
      wd        <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_rdata  <= '0;
      dm_ready  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (busy) begin
        if (state == S_IF_BUSY && if_flush) kill <= 1'b1;
        if (mem_ack || timeout) begin
          state  <= S_DONE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // Ack wins over a coincident timeout; stores leave dm_rdata untouched.
          if (mem_ack) begin
            if (state == S_IF_BUSY) if_rdata <= mem_rdata;
            else if (!mem_we)       dm_rdata <= mem_rdata;
          end else begin
            bus_err <= 1'b1;
            if (state == S_IF_BUSY) if_rdata <= ERR_DATA;
            else                    dm_rdata <= ERR_DATA;
          end
          dm_ready <= (state == S_DM_BUSY);
          if_ready <= (state == S_IF_BUSY) && !kill && !if_flush;
        end else begin
          wd <= wd + WW'(1);
        end
      end else if (grant_dm || grant_if) begin
        state     <= grant_dm ? S_DM_BUSY : S_IF_BUSY;
        owner_dm  <= grant_dm;
        kill      <= 1'b0;
        wd        <= '0;
        mem_en    <= 1'b1;
        mem_we    <= grant_dm & dm_we;
        mem_addr  <= grant_dm ? dm_addr : if_addr;
        mem_wdata <= grant_dm ? dm_wdata : '0;
      end else begin
        state  <= S_IDLE;
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end
    end
  end

endmodule
